// File: rtl/pp_accumulator.sv
// Partial-product group accumulator: sums signed, exponent-shifted beats into an
// ACC_W-bit result per group. Define PP_ACC_SAT_EN for saturating sums (default: wrap).
module pp_accumulator #(
  parameter int ACC_W     = 48,
  parameter int MAX_TERMS = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [3:0]                   in_pp,
  input  logic [5:0]                   in_exp,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ACC_W-1:0]             out_sum,
  output logic [$clog2(MAX_TERMS):0]   out_count,
  output logic                         out_ovf
);
  localparam int CNT_W = $clog2(MAX_TERMS) + 1;

  typedef enum logic {ACCUM, DONE} state_t;
  state_t state, state_nxt;

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] count;
  logic             ovf;

  logic             range_err, sum_ovf, in_hs, out_hs, closing;
  logic [39:0]      mag;
  logic [ACC_W-1:0] term, acc_add;
  logic [ACC_W:0]   sum_ext;
  logic [CNT_W-1:0] count_inc;

  assign in_hs  = in_valid & in_ready;
  assign out_hs = out_valid & out_ready;

  // Exponents past 37 would spill the 40-bit magnitude; such beats add nothing.
  assign range_err = in_exp > 6'd37;
  assign mag       = range_err ? 40'd0 : (40'(in_pp[2:0]) << in_exp);
  assign term      = in_pp[3] ? -ACC_W'(mag) : ACC_W'(mag);

  // One guard bit: overflow iff the top two bits of the extended sum disagree.
  assign sum_ext   = {acc[ACC_W-1], acc} + {term[ACC_W-1], term};
  assign sum_ovf   = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
  assign count_inc = count + 1'b1;
  assign closing   = in_last || (count_inc == CNT_W'(MAX_TERMS));

`ifdef PP_ACC_SAT_EN
  always_comb begin
    acc_add = sum_ext[ACC_W-1:0];
    if (sum_ovf)
      acc_add = sum_ext[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  end
`else
  assign acc_add = sum_ext[ACC_W-1:0];
`endif

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        if (in_hs && closing) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ACCUM;
      end
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else if (in_hs) begin
      acc   <= acc_add;
      count <= count_inc;
      ovf   <= ovf | range_err | sum_ovf;
      if (closing) begin
        out_sum   <= acc_add;
        out_count <= count_inc;
        out_ovf   <= ovf | range_err | sum_ovf;
      end
    end else if (out_hs) begin
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end
  end
endmodule

// File: tb/tb_pp_accumulator.sv
// Directed self-checking bench for pp_accumulator (ACC_W=42 so the overflow vectors apply).
module tb_pp_accumulator;
  localparam int ACC_W = 42;
  localparam int MAX_TERMS = 64;

  logic              clk = 1'b0;
  logic              rst, in_valid, in_last, out_ready;
  logic              in_ready, out_valid, out_ovf;
  logic [3:0]        in_pp;
  logic [5:0]        in_exp;
  logic [ACC_W-1:0]  out_sum;
  logic [6:0]        out_count;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pp_accumulator #(.ACC_W(ACC_W), .MAX_TERMS(MAX_TERMS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pp(in_pp),
    .in_exp(in_exp), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_beat(input logic [3:0] pp, input logic [5:0] e, input logic last);
    in_valid = 1'b1; in_pp = pp; in_exp = e; in_last = last;
    step();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_sum !== '0) begin n_fail++; $display("FAIL reset_out_sum: got %0d want 0", out_sum); end
    n_cmp++; if (out_count !== 7'd0) begin n_fail++; $display("FAIL reset_out_count: got %0d want 0", out_count); end
    n_cmp++; if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_out_ovf: got %b want 0", out_ovf); end
    rst = 1'b0;
    step();
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_single();
    send_beat(4'b0101, 6'd3, 1'b1);
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_sum !== 42'd40) begin n_fail++; $display("FAIL single_sum: got %0d want 40", out_sum); end
    n_cmp++; if (out_count !== 7'd1) begin n_fail++; $display("FAIL single_count: got %0d want 1", out_count); end
    n_cmp++; if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL single_ovf: got %b want 0", out_ovf); end
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL single_in_ready: got %b want 0", in_ready); end
    drain();
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL single_release: got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid); end
  endtask

  task automatic test_backpressure();
    send_beat(4'b0101, 6'd2, 1'b0);
    send_beat(4'b1110, 6'd0, 1'b1);
    // Offer a beat during DONE; it must be ignored.
    in_valid = 1'b1; in_pp = 4'b0111; in_exp = 6'd5; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hs cyc%0d: got vld=%b rdy=%b want vld=1 rdy=0", i, out_valid, in_ready); end
      n_cmp++; if (out_sum !== 42'd14) begin n_fail++; $display("FAIL bp_sum cyc%0d: got %0d want 14", i, $signed(out_sum)); end
      n_cmp++; if (out_count !== 7'd2) begin n_fail++; $display("FAIL bp_count cyc%0d: got %0d want 2", i, out_count); end
      step();
    end
    in_valid = 1'b0; in_last = 1'b0;
    drain();
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: got %b want 1", in_ready); end
    send_beat(4'b0100, 6'd0, 1'b1);
    n_cmp++; if (out_sum !== 42'd4 || out_count !== 7'd1) begin n_fail++; $display("FAIL bp_next_group: got sum=%0d cnt=%0d want 4/1", out_sum, out_count); end
    drain();
  endtask

  task automatic test_forced_close();
    for (int i = 0; i < 63; i++) send_beat(4'b0100, 6'd0, 1'b0);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL force_early: got %b want 0", out_valid); end
    send_beat(4'b0100, 6'd0, 1'b0);
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL force_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_sum !== 42'd256 || out_count !== 7'd64) begin n_fail++; $display("FAIL force_result: got sum=%0d cnt=%0d want 256/64", out_sum, out_count); end
    drain();
    for (int i = 0; i < 64; i++) send_beat(i == 30 ? 4'b0000 : 4'b0100, 6'd0, 1'b0);
    n_cmp++; if (out_sum !== 42'd252 || out_count !== 7'd64 || out_ovf !== 1'b0) begin n_fail++; $display("FAIL force_zero_beat: got sum=%0d cnt=%0d ovf=%b want 252/64/0", out_sum, out_count, out_ovf); end
    drain();
  endtask

  task automatic test_overflow();
    logic [ACC_W-1:0] want;
`ifdef PP_ACC_SAT_EN
    want = 42'd2199023255551;
`else
    want = 42'd4398046511104 - 42'd1511828488192;
`endif
    send_beat(4'b0111, 6'd37, 1'b0);
    send_beat(4'b0111, 6'd37, 1'b0);
    send_beat(4'b0111, 6'd37, 1'b1);
    n_cmp++; if (out_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", out_ovf); end
    n_cmp++; if (out_sum !== want) begin n_fail++; $display("FAIL ovf_sum: got %0d want %0d", $signed(out_sum), $signed(want)); end
    n_cmp++; if (out_count !== 7'd3) begin n_fail++; $display("FAIL ovf_count: got %0d want 3", out_count); end
    drain();
    send_beat(4'b0101, 6'd0, 1'b1);
    n_cmp++; if (out_ovf !== 1'b0 || out_sum !== 42'd5) begin n_fail++; $display("FAIL ovf_cleared: got ovf=%b sum=%0d want 0/5", out_ovf, out_sum); end
    drain();
  endtask

  task automatic test_range();
    send_beat(4'b0101, 6'd2, 1'b0);
    send_beat(4'b0110, 6'd40, 1'b1);
    n_cmp++; if (out_sum !== 42'd20 || out_count !== 7'd2) begin n_fail++; $display("FAIL range_result: got sum=%0d cnt=%0d want 20/2", out_sum, out_count); end
    n_cmp++; if (out_ovf !== 1'b1) begin n_fail++; $display("FAIL range_ovf: got %b want 1", out_ovf); end
    drain();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) send_beat(4'b0111, 6'd4, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_state: got vld=%b rdy=%b want 0/1", out_valid, in_ready); end
      step();
    end
    send_beat(4'b0011, 6'd1, 1'b1);
    n_cmp++; if (out_sum !== 42'd6 || out_count !== 7'd1 || out_ovf !== 1'b0) begin n_fail++; $display("FAIL rstmid_next: got sum=%0d cnt=%0d ovf=%b want 6/1/0", out_sum, out_count, out_ovf); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || out_sum !== '0 || out_count !== 7'd0) begin n_fail++; $display("FAIL rstdone: got vld=%b sum=%0d cnt=%0d want 0/0/0", out_valid, out_sum, out_count); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_pp = '0; in_exp = '0; in_last = 1'b0; out_ready = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_forced_close();
    test_overflow();
    test_range();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/pp_accumulator.md
PP_ACCUMULATOR -- requirements
Module: pp_accumulator

Interface
REQ-001 The block SHALL have a parameter ACC_W, default 48, giving the signed accumulator width; legal values are 42 or more.
REQ-002 The block SHALL have a parameter MAX_TERMS, default 64, giving the maximum number of beats in one group.
REQ-003 The block SHALL have one clock and a reset that is synchronous and active-high.
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  an upstream partial-product beat is present.
REQ-007 in_ready  output  1  the block accepts a beat this cycle.
REQ-008 in_pp  input  4  denormalized partial product {sign, leading one, 2-bit mantissa}; 4'd0 means a zero term.
REQ-009 in_exp  input  6  unsigned combined exponent of the beat.
REQ-010 in_last  input  1  this beat closes the group.
REQ-011 out_valid  output  1  the group result is available.
REQ-012 out_ready  input  1  the downstream stage accepts the result.
REQ-013 out_sum  output  ACC_W  two's-complement group sum.
REQ-014 out_count  output  clog2(MAX_TERMS)+1  number of beats in the group.
REQ-015 out_ovf  output  1  sticky overflow/out-of-range flag for the group.

Function
REQ-016 Term magnitude SHALL be the 40-bit value in_pp[2:0] << in_exp when in_exp <= 37.
REQ-017 Term SHALL be the negated magnitude when in_pp[3]=1, otherwise the magnitude itself, sign-extended to ACC_W.
REQ-018 A beat with in_exp > 37 SHALL contribute 0 and set the group ovf flag.
REQ-019 The FSM SHALL have exactly two states: ACCUM (in_ready=1, out_valid=0) and DONE (in_ready=0, out_valid=1).
REQ-020 In ACCUM, a handshake (in_valid & in_ready) SHALL update acc to acc+term and count to count+1.
REQ-021 A handshake with in_last=1, or the handshake that makes count equal MAX_TERMS, SHALL load out_sum/out_count/out_ovf and move to DONE.
REQ-022 Result latency SHALL be 1 cycle: out_valid rises on the edge that captures the closing beat.
REQ-023 In DONE, out_sum, out_count and out_ovf SHALL stay stable until out_valid & out_ready.
REQ-024 On the out_valid & out_ready handshake, acc, count and ovf SHALL clear and the FSM SHALL return to ACCUM, so in_ready=1 on the next cycle.
REQ-025 The block SHALL insert a mandatory one-cycle bubble and SHALL have no same-cycle input/output bypass.
REQ-026 When acc+term exceeds the signed ACC_W range, ovf SHALL be set and remain sticky until the output handshake.
REQ-027 in_valid while in_ready=0 SHALL be ignored, and upstream holds the beat.
REQ-028 Zero beats (in_pp=0, any exp <= 37) SHALL still increment count.

Reset
REQ-029 While rst=1, the FSM SHALL be in ACCUM and acc, out_sum, out_count and out_ovf SHALL be 0.
REQ-030 While rst=1, out_valid SHALL be 0 and in_ready SHALL be 1 on the first cycle after rst falls.
REQ-031 rst asserted mid-group or in DONE SHALL discard all partial state; no result is emitted.

Configuration
REQ-032 The block SHALL define the macro PP_ACC_SAT_EN.
REQ-033 With PP_ACC_SAT_EN defined, overflowing sums SHALL clamp to +(2^(ACC_W-1)-1) or -2^(ACC_W-1), and later beats SHALL add to the clamped value.
REQ-034 Without PP_ACC_SAT_EN, sums SHALL wrap modulo 2^ACC_W; ovf SHALL still be set as in REQ-026.

Verification
REQ-035 Reset: rst=1 for 2 cycles -> in_ready=1, out_valid=0, out_sum=0, out_count=0, out_ovf=0.
REQ-036 Single beat: in_pp=4'b0101, in_exp=3, in_last=1 -> next cycle out_valid=1, out_sum=40, out_count=1.
REQ-037 Mixed signs and backpressure: beats (0101, exp 2) then (1110, exp 0, last), out_ready=0 for 5 cycles -> out_sum=14 and out_count=2 held stable, in_ready=0 throughout; after out_ready=1, in_ready=1 next cycle.
REQ-038 Forced close: 64 beats of (0100, exp 0) with in_last=0 -> DONE after the 64th beat, out_sum=256, out_count=64; a zero beat (0000, exp 0) mid-group changes count only.
REQ-039 Overflow, ACC_W=42: three beats (0111, exp 37) -> out_ovf=1; out_sum=2199023255551 with PP_ACC_SAT_EN, -1511828488192 without.
REQ-040 Range and reset: a beat with in_exp=40 -> contributes 0 and out_ovf=1; rst pulsed after 3 beats of a group -> no out_valid, and the next group sums from 0.
